key_sender: RTL and testbench
=============================

Name: key_sender

Overview:
- Transmitter end of the E-lock button protocol.
- On a start request, replays a stored combination as single-cycle B0/B1 pulses, spaced apart, into the lock FSM's inputs.
- Emits a leading clear pulse on the lock's soft-reset line so the lock starts from its initial state.
- Used for self-test and demo on the board: its outputs substitute for the debounced button_unit outputs feeding the lock FSM.

Parameters:
- CODE_LEN, 4, number of code bits sent; legal range 1..7.
- GAP, 8, idle cycles before each data pulse; minimum 1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle request; sampled only in IDLE
- abort  input  1  cancels a transfer in progress
- code  input  CODE_LEN  combination to send, MSB first; 1 → B1 pulse, 0 → B0 pulse
- reset_s  output  1  clear pulse to the lock FSM
- B0  output  1  data pulse for a 0 bit
- B1  output  1  data pulse for a 1 bit
- busy  output  1  high in every state except IDLE
- done  output  1  single-cycle completion strobe
- sent  output  3  count of data pulses emitted so far in the current transfer, for 7-seg display

Behaviour:
- Reset and abort:
  - Synchronous, active-high reset overrides everything.
  - Next cycle: state=IDLE; all outputs 0; gap counter, bit index and sent cleared.
  - Reset mid-transfer gives no done and no further pulses.
- Moore machine: all outputs decode from registered state, counters and shift register; no combinational path from input to output.
- States:
  - IDLE: busy=0. start=1 → latch code into shift register, clear sent, go to CLR. code changes outside IDLE are ignored.
  - CLR: one cycle, reset_s=1. Load gap counter with GAP-1, go to WAIT.
  - WAIT: outputs quiet. Decrement gap counter; at 0 go to SEND.
  - SEND: one cycle, B1=msb or B0=~msb, exactly one of the two high. Shift register left by 1; sent increments at the end of the cycle.
    - If bits remain: reload counter, go to WAIT.
    - Else: go to DONE.
  - DONE: one cycle, done=1, busy=1; then IDLE. sent holds CODE_LEN until the next start.
- Timing, start seen in IDLE at cycle 0, defaults (CODE_LEN=4, GAP=8):
  - reset_s high at cycle 1.
  - Data pulses at cycles 10, 19, 28, 37 (first at 1+GAP+1, then every GAP+1).
  - done at cycle 38; start accepted again from cycle 39.
  - busy high cycles 1..38.
  - Total busy cycles = 2 + CODE_LEN*(GAP+1).
- Boundary rules:
  - start while busy: ignored, no queuing.
  - start in the same cycle as DONE: ignored; it must be reasserted in IDLE.
  - abort in any busy state: IDLE next cycle, no done. sent keeps its value until the next start.
  - abort and start together in IDLE: start wins (abort is a no-op in IDLE).
  - reset and any input together: reset wins.
  - Gap counter width = clog2(GAP)+1; no wrap can occur. sent saturates at CODE_LEN.
  - reset_s, B0, B1 are never high in the same cycle.

Decomposition:
- Shared package key_pkg:
  - State encoding localparams: IDLE, CLR, WAIT, SEND, DONE (3-bit).
  - Default CODE_LEN/GAP constants, shared with the lock FSM so both agree on code length.
- One natural sub-module, gap_timer: loadable down-counter with a zero flag, inputs load/value/en.
- Shift register and FSM stay in key_sender.
- A top-level loopback wrapper connects key_sender to the existing FSM and dorcodor; it is outside this block.

Test Plan:
- After reset, code=4'b1011, start pulse at cycle 0 → reset_s@1; B1@10, B0@19, B1@28, B1@37; done@38; busy 1..38; sent steps 1,2,3,4.
- code=4'b0000 → four B0 pulses at 10/19/28/37, B1 never high; then code=4'b1111 → four B1 pulses, same timing.
- start held high for 20 cycles from cycle 0 → exactly one transfer; no restart until start reasserted at/after cycle 39.
- abort at cycle 20 with code=4'b1011 → pulses only at 10 and 19; busy=0 from cycle 21; done never asserted; sent=2.
- reset at cycle 15 → all outputs 0 at cycle 16; new start at cycle 17 → reset_s@18, first data pulse @27.
- Loopback with the lock FSM: send the lock's valid combination → lock LED asserts after done; send a wrong combination → LED stays 0.

Source files
------------

// File: rtl/key_pkg.sv
// Shared constants for the E-lock button protocol: state encoding and the default
// code length/gap agreed between key_sender and the lock FSM.
package key_pkg;

  localparam int DEF_CODE_LEN = 4;
  localparam int DEF_GAP      = 8;

  typedef logic [2:0] state_t;

  localparam state_t IDLE = 3'd0;
  localparam state_t CLR  = 3'd1;
  localparam state_t WAIT = 3'd2;
  localparam state_t SEND = 3'd3;
  localparam state_t DONE = 3'd4;

endpackage

// File: rtl/key_sender_gap_timer.sv
// Loadable down-counter with zero flag; load has priority over decrement,
// and the count parks at zero instead of wrapping.
module gap_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/key_sender.sv
// Replays a stored combination as spaced B0/B1 pulses after a leading reset_s clear pulse.
// Moore outputs only; start is honoured in IDLE, abort returns to IDLE without done.
module key_sender
  import key_pkg::*;
#(
  parameter int CODE_LEN = DEF_CODE_LEN,
  parameter int GAP      = DEF_GAP
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [CODE_LEN-1:0] code,
  output logic                reset_s,
  output logic                B0,
  output logic                B1,
  output logic                busy,
  output logic                done,
  output logic [2:0]          sent
);

  localparam int         GW   = $clog2(GAP) + 1;
  localparam logic [2:0] LEN3 = 3'(CODE_LEN);

  state_t              state_q, state_d;
  logic [CODE_LEN-1:0] shift_q;
  logic [2:0]          sent_q;
  logic                tmr_zero;
  logic                tmr_load;
  logic                tmr_en;
  logic                last_bit;

  // sent doubles as the bit index: the pulse in flight is the last one when
  // CODE_LEN-1 pulses have already gone out.
  assign last_bit = (sent_q == (LEN3 - 3'd1));
  assign tmr_load = (state_q == CLR) || ((state_q == SEND) && !last_bit);
  assign tmr_en   = (state_q == WAIT);

  gap_timer #(.W(GW)) u_gap_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .value (GW'(GAP - 1)),
    .en    (tmr_en),
    .zero  (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CLR;
      CLR:     state_d = abort ? IDLE : WAIT;
      WAIT:    if (abort) state_d = IDLE;
               else if (tmr_zero) state_d = SEND;
      SEND:    if (abort) state_d = IDLE;
               else state_d = last_bit ? DONE : WAIT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      sent_q  <= '0;
    end else if ((state_q == IDLE) && start) begin
      shift_q <= code;
      sent_q  <= '0;
    end else if (state_q == SEND) begin
      shift_q <= shift_q << 1;
      if (sent_q != LEN3) sent_q <= sent_q + 3'd1;
    end
  end

  always_comb begin
    reset_s = 1'b0;
    B0      = 1'b0;
    B1      = 1'b0;
    busy    = (state_q != IDLE);
    done    = 1'b0;
    case (state_q)
      CLR:     reset_s = 1'b1;
      SEND: begin
        B1 = shift_q[CODE_LEN-1];
        B0 = ~shift_q[CODE_LEN-1];
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign sent = sent_q;

endmodule

// File: tb/tb_key_sender.sv
// Directed bench for key_sender: per-cycle comparison of all outputs against
// a timing model derived from the protocol's pulse schedule.
module tb_key_sender;

  localparam int LEN    = 4;
  localparam int GAP    = 8;
  localparam int DONE_T = 2 + LEN * (GAP + 1);
  localparam int NONE   = 100000;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           abort;
  logic [LEN-1:0] code;
  logic           reset_s, B0, B1, busy, done;
  logic [2:0]     sent;

  int checks   = 0;
  int failures = 0;

  key_sender #(.CODE_LEN(LEN), .GAP(GAP)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .code    (code),
    .reset_s (reset_s),
    .B0      (B0),
    .B1      (B1),
    .busy    (busy),
    .done    (done),
    .sent    (sent)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // {reset_s, B0, B1, busy, done, sent} expected t cycles after start was sampled
  function automatic logic [7:0] exp_out(input int t, input logic [LEN-1:0] c,
                                         input int a, input int r);
    logic rs, b0, b1, bz, dn;
    int   s, p;
    if (t > r) return 8'h00;
    rs = (t == 1);
    bz = (t >= 1) && (t <= DONE_T) && (t <= a);
    dn = (t == DONE_T) && (t <= a);
    b0 = 1'b0;
    b1 = 1'b0;
    s  = 0;
    for (int k = 0; k < LEN; k++) begin
      p = 1 + (k + 1) * (GAP + 1);
      if ((t == p) && (t <= a)) begin
        b1 = c[LEN-1-k];
        b0 = ~c[LEN-1-k];
      end
      if ((p < t) && (p <= a)) s++;
    end
    return {rs, b0, b1, bz, dn, 3'(s)};
  endfunction

  task automatic check(input string tag, input int t, input logic [7:0] obs,
                       input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s t=%0d obs=%b required=%b", tag, t, obs, expv);
    end
  endtask

  // One transfer from the current cycle (t=0). start is held for start_len
  // cycles, optionally pulsed again at extra_start; abort/reset pulse once.
  task automatic xfer(input string tag, input logic [LEN-1:0] c, input int start_len,
                      input int extra_start, input int abort_cyc, input int reset_cyc,
                      input int horizon);
    int a_eff;
    a_eff = (abort_cyc >= 1) ? abort_cyc : NONE;
    for (int t = 0; t <= horizon; t++) begin
      if (t >= 1)
        check(tag, t, {reset_s, B0, B1, busy, done, sent}, exp_out(t, c, a_eff, reset_cyc));
      start = (t < start_len) || (t == extra_start);
      abort = (t == abort_cyc);
      reset = (t == reset_cyc);
      code  = (t == 0) ? c : ~c;
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    code  = '0;
    tick();
    tick();
    check("reset_hold", 0, {reset_s, B0, B1, busy, done, sent}, 8'h00);
    reset = 1'b0;
    tick();
    check("reset_idle", 0, {reset_s, B0, B1, busy, done, sent}, 8'h00);

    xfer("code1011", 4'b1011, 1, NONE, NONE, NONE, 40);
    xfer("code0000", 4'b0000, 1, NONE, NONE, NONE, 40);
    xfer("code1111", 4'b1111, 1, NONE, NONE, NONE, 38);
    // restart accepted immediately at cycle 39 of the previous transfer
    xfer("start_held", 4'b0110, 20, NONE, NONE, NONE, 38);
    xfer("start_in_done", 4'b1001, 1, 38, NONE, NONE, 41);
    xfer("abort_wait", 4'b1011, 1, NONE, 20, NONE, 25);
    xfer("abort_send", 4'b0100, 1, NONE, 19, NONE, 24);
    xfer("abort_idle", 4'b0101, 1, NONE, 0, NONE, 40);
    xfer("reset_mid", 4'b1011, 1, NONE, NONE, 15, 16);
    xfer("after_reset", 4'b1100, 1, NONE, NONE, NONE, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
